// File: rtl/bcd_to_bin.sv
// Packed-BCD to binary converter using reverse double-dabble, one shift per clock.
// Optional BCD_ERR_EN adds an err output that flags non-decimal nibbles.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  rdy,
`ifdef BCD_ERR_EN
  output logic                  err,
`endif
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]      state;
  logic [2*BW-1:0] w;
  logic [2*BW-1:0] w_nxt;
  logic [CW-1:0]   cnt;

`ifdef BCD_ERR_EN
  logic            inv;
  logic            inv_in;

  always_comb begin
    inv_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) inv_in = 1'b1;
    end
  end
`endif

  // Shift right, then pull 3 out of any digit that received a carried-in 8.
  always_comb begin
    w_nxt = w >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_nxt[BW+4*i +: 4] >= 4'd8)
        w_nxt[BW+4*i +: 4] = w_nxt[BW+4*i +: 4] - 4'd3;
    end
  end

  assign busy = (state == S_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      w       <= '0;
      cnt     <= '0;
      bin_out <= '0;
      rdy     <= 1'b0;
`ifdef BCD_ERR_EN
      inv     <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            w     <= {bcd_in, {BW{1'b0}}};
            cnt   <= '0;
            state <= S_SHIFT;
`ifdef BCD_ERR_EN
            inv   <= inv_in;
`endif
          end
        end
        S_SHIFT: begin
          w   <= w_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BW - 1)) state <= S_DONE;
        end
        S_DONE: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
`ifdef BCD_ERR_EN
          err     <= inv;
          bin_out <= inv ? '0 : w[BIN_W-1:0];
`else
          bin_out <= w[BIN_W-1:0];
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: driver queues expected results,
// monitor checks value and arrival cycle on every rdy pulse.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] bcd_in;
  logic [13:0] bin_out;
  logic        rdy;
  logic        busy;
`ifdef BCD_ERR_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int val;
    int cyc;
    bit err;
  } exp_t;

  exp_t q[$];

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .rdy     (rdy),
`ifdef BCD_ERR_EN
    .err     (err),
`endif
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal meaning of the digits, straight from place values.
  function automatic exp_t model(input logic [15:0] b, input int c);
    exp_t e;
    int v;
    bit bad;
    logic [3:0] d;
    v = 0;
    bad = 0;
    for (int i = 3; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1;
      v = v * 10 + int'(d);
    end
`ifdef BCD_ERR_EN
    e.val = bad ? 0 : v;
    e.err = bad;
`else
    e.val = v;
    e.err = 0;
`endif
    e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rdy) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy: got rdy=1 expected none (cyc %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("bin_out", int'(bin_out), e.val);
        chk("rdy_cycle", cyc, e.cyc);
`ifdef BCD_ERR_EN
        chk("err", int'(err), int'(e.err));
`endif
      end
    end
  end

  // Issue a one-cycle en pulse at a negedge; returns one negedge after load.
  task automatic pulse(input logic [15:0] b, input bit push);
    @(negedge clk);
    bcd_in = b;
    en = 1'b1;
    if (push) q.push_back(model(b, cyc + 18));
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_rdy(output int nb);
    int i;
    nb = 0;
    for (i = 0; i < 60; i++) begin
      if (rdy) break;
      if (busy) nb++;
      @(negedge clk);
    end
    if (i == 60) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout: got no rdy expected one within 60 cycles");
    end
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int nb;
    int c;
    logic [15:0] b;
    reset = 1'b1;
    en = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_bin_out", int'(bin_out), 0);
    chk("reset_rdy", int'(rdy), 0);
    chk("reset_busy", int'(busy), 0);

    pulse(16'h1234, 1);
    wait_rdy(nb);
    chk("busy_cycles", nb, 16);
    chk("busy_at_rdy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("bin_out_hold", int'(bin_out), 1234);

    pulse(16'h9999, 1);
    wait_rdy(nb);
    bcd_in = 16'h0000;
    en = 1'b1;
    q.push_back(model(16'h0000, cyc + 18));
    @(negedge clk);
    en = 1'b0;
    wait_rdy(nb);
    @(negedge clk);

    pulse(16'h0500, 1);
    repeat (3) @(negedge clk);
    bcd_in = 16'h0001;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_rdy(nb);
    repeat (20) @(negedge clk);

    pulse(16'h4321, 0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_bin_out", int'(bin_out), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_rdy", int'(rdy), 0);
    repeat (25) @(negedge clk);
    pulse(16'h0042, 1);
    wait_rdy(nb);
    @(negedge clk);

    bcd_in = 16'h0007;
    en = 1'b1;
    c = cyc;
    for (int j = 0; j < 3; j++) q.push_back(model(16'h0007, c + 18 + 18 * j));
    repeat (40) @(negedge clk);
    en = 1'b0;
    wait_drain();

`ifdef BCD_ERR_EN
    pulse(16'h12A4, 1);
    wait_rdy(nb);
    @(negedge clk);
    pulse(16'h0010, 1);
    wait_rdy(nb);
    @(negedge clk);
`endif

    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < 4; d++) b[4*d +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD_ERR_EN
      if ($urandom_range(0, 3) == 0)
        b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
`endif
      pulse(b, 1);
      wait_rdy(nb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential packed-BCD to unsigned binary converter; the inverse of the team's binary-to-BCD (double-dabble) converter.
- Used where decimal values from switches, keypad or display registers must become binary for counters and comparators.
- Algorithm: reverse double-dabble. One right shift per clock, with a per-digit correction. Start/ready handshake matches the forward converter's en/rdy style.

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (bcd_in width = 4*DIGITS).
- BIN_W, 14, width of bin_out; must be >= ceil(log2(10^DIGITS)), which is 14 for 4 digits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  start request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 is in bits [3:0].
- bin_out  output  BIN_W  converted value; held until the next conversion completes.
- rdy  output  1  one-cycle pulse; bin_out is valid and updated in the same cycle.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- err  output  1  present only with BCD_ERR_EN; see Optional Feature.

Behaviour:
- Reset, applied at any time including mid-conversion:
  - state=IDLE; bin_out=0, rdy=0, busy=0, err=0.
  - Internal shift register and iteration counter cleared.
- Internal working register W, width 4*DIGITS + 4*DIGITS: upper half holds BCD digits, lower half accumulates binary.
- Iteration counter runs 0..4*DIGITS-1.
- IDLE:
  - en=1 at edge k: W <= {bcd_in, 0}, counter <= 0, state <= SHIFT, busy=1 from that edge.
  - en=0: no change.
- SHIFT, each edge:
  - W is shifted right 1 bit (0 into MSB).
  - Then every BCD nibble in the upper half that is >= 8 has 3 subtracted.
  - Shift and correction complete within the same cycle.
  - Counter increments.
  - After the 4*DIGITS-th shift (edge k+16 for DIGITS=4), state <= DONE.
- DONE, one cycle (edge k+17):
  - bin_out <= W[BIN_W-1:0] (lower half, truncated to BIN_W); rdy <= 1; busy <= 0; state <= IDLE.
- Latency: en sampled at edge k, rdy high after edge 4*DIGITS+1 (17 for DIGITS=4), for exactly one cycle.
- While SHIFT/DONE, en is ignored (no queueing). bcd_in may change freely after the load edge.
- Back-to-back: en may be high in the IDLE cycle right after the rdy pulse; the next conversion loads there. Maximum throughput is one result per 4*DIGITS+2 cycles.
- en held high continuously gives repeated conversions at that rate.
- Overflow is impossible for valid input given the BIN_W rule; upper bits of the lower half are zero.
- Without error checking, non-BCD nibbles (A-F) are not trapped; the result is whatever the algorithm deterministically produces.

Optional Feature:
- Macro: BCD_ERR_EN.
- Defined:
  - err port exists.
  - At the load edge, any bcd_in nibble > 9 sets an internal invalid flag.
  - Conversion still runs the full 4*DIGITS+1 cycles, so latency stays fixed.
  - In DONE: bin_out <= 0, err <= 1, rdy pulses.
  - err holds until the next rdy pulse or reset. A valid conversion clears it (err <= 0 with rdy).
- Undefined: no err port and no nibble check; all other behaviour identical.

Test Plan:
- Reset, then bcd_in=16'h1234, 1-cycle en pulse -> busy=1 for 16 cycles; rdy=1 for one cycle at edge 17; bin_out=14'd1234 (0x4D2); busy=0.
- bcd_in=16'h9999 then 16'h0000, back-to-back (en high in the cycle after rdy) -> bin_out=9999 (0x270F), then 0; exactly 18 cycles between rdy pulses.
- Start 16'h0500; change bcd_in to 16'h0001 and pulse en at cycle 5 -> en ignored; result 500; no second rdy.
- Start 16'h4321; assert reset at cycle 8 -> bin_out=0, busy=0, rdy never pulses; new en with 16'h0042 -> 42 at +17 cycles.
- Hold en=1 for 40 cycles with 16'h0007 -> rdy pulses at cycles 17 and 35; bin_out=7.
- With BCD_ERR_EN, bcd_in=16'h12A4 -> rdy at 17 with err=1, bin_out=0; then 16'h0010 -> err=0, bin_out=10.
